seg7_scan_ctrl: RTL and testbench
=================================

SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 The block SHALL have parameter DIGIT_TICKS, default 50000, clock cycles per digit slot (blank plus show), legal range 4 to 2^20.
REQ-002 The block SHALL have parameter BLANK_TICKS, default 2000, leading cycles of each slot with all anodes off, legal range 1 to DIGIT_TICKS-2.
REQ-003 clk  input  1  the single clock; every register changes on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 en  input  1  scan enable; 0 SHALL blank the display and hold the scan.
REQ-006 lz_en  input  1  leading-zero suppression enable.
REQ-007 load_valid  input  1  a new 4-digit value is offered.
REQ-008 load_data  input  16  BCD digits; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
REQ-009 load_ready  output  1  the block can accept load_data.
REQ-010 bcd  output  4  nibble for the shared decoder; bit 3 drives b3 and bit 0 drives b0.
REQ-011 an_n  output  4  active-low digit enables; bit k is digit k.
REQ-012 frame_done  output  1  one-cycle pulse at the end of the digit-3 show phase.

Function
REQ-013 A load SHALL be accepted on a cycle where load_valid=1 and load_ready=1; the data is captured into a pending register and load_ready goes 0 on the next cycle.
REQ-014 The pending value SHALL be copied to the active register at the frame boundary, which is the cycle frame_done=1; load_ready SHALL return to 1 on the following cycle.
REQ-015 While the state is IDLE, an accepted load SHALL be copied to the active register on the next cycle without waiting for a frame boundary.
REQ-016 The block SHALL have states IDLE, BLANK and SHOW.
- IDLE to BLANK: on en=1, with digit index 0 and tick counter 0.
- BLANK to SHOW: when tick = BLANK_TICKS-1.
- SHOW to BLANK: when tick = DIGIT_TICKS-1; the tick counter resets to 0 and the digit index increments mod 4 (3 wraps to 0).
- Any state to IDLE: on en=0 at the next edge; digit index and tick counter clear to 0.
REQ-017 The tick counter SHALL count 0 to DIGIT_TICKS-1 across BLANK and SHOW.
- It is wide enough for DIGIT_TICKS-1.
- Wrap-around SHALL be exact, so one full frame is 4*DIGIT_TICKS cycles.
REQ-018 In IDLE and BLANK, an_n SHALL be 4'b1111.
REQ-019 In SHOW, an_n SHALL have exactly one bit low, at the current digit index.
REQ-020 In SHOW, bcd SHALL equal the active nibble of the current digit, registered and aligned with an_n.
REQ-021 In BLANK, bcd SHALL already hold the nibble for the upcoming digit, so the decoder is stable before its anode turns on.
REQ-022 Nibbles 10 to 15 SHALL pass through to bcd unmodified.
REQ-023 When lz_en=1, digit k (k = 3, 2 or 1) SHALL be suppressed, with an_n held 1 during its SHOW, if active digit k and every higher active digit are 0.
- Digit 0 is never suppressed.
REQ-024 frame_done SHALL pulse high for one cycle when in SHOW with digit index 3 and tick = DIGIT_TICKS-1, and never otherwise.
REQ-025 If a load is accepted in the same cycle as frame_done, the old pending value (if any) SHALL commit, then the new value becomes pending.
- Since load_ready=0 whenever a value is pending, this case only arises with an empty pending register.
- The new value therefore commits at the next frame boundary.
REQ-026 A mid-frame en=0 SHALL NOT discard a pending value; it commits on the next IDLE cycle per REQ-015.

Reset
REQ-027 While rst_n=0, regardless of clk, the block SHALL hold:
- state = IDLE, tick = 0, digit index = 0
- active = 16'h0000, pending empty
- bcd = 4'h0, an_n = 4'b1111, load_ready = 1, frame_done = 0
REQ-028 Reset asserted mid-frame SHALL discard both the active and the pending values.
REQ-029 After rst_n deasserts, the first state change SHALL occur on the first rising clk edge on which en=1.

Verification (DIGIT_TICKS=8, BLANK_TICKS=2)
REQ-030 Reset scenario: assert rst_n=0 mid-SHOW -> the same cycle shows an_n=4'b1111, bcd=0 and load_ready=1, with no clock edge needed.
REQ-031 Load-in-IDLE scenario: en=0, load 16'h1234, then en=1 -> slots show an_n=1110 with bcd=4, 1101 with 3, 1011 with 2, 0111 with 1.
- Each slot has 2 blank cycles then 6 show cycles.
- frame_done is high at cycle 32 of the frame.
REQ-032 Deferred-load scenario: mid-frame load 16'h5678 while showing 16'h1234 -> load_ready=0 until the cycle after frame_done; the current frame stays 1234 and the next frame shows 5678.
REQ-033 Leading-zero scenario: lz_en=1, active 16'h0050 -> digits 3 and 2 stay dark, digit 1 shows 5, digit 0 shows 0; 16'h0000 lights only digit 0.
REQ-034 Enable-drop scenario: en=0 during digit 2 SHOW -> an_n=1111 on the next cycle; on re-enable, the scan restarts at digit 0 BLANK.
REQ-035 Exhaustive scenario: sweep all 16 nibble values through digit 0 -> bcd equals the input value, including 10 to 15.

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 4-digit 7-segment scan controller: time-slots each digit into a blank
// phase then a show phase, with double-buffered BCD load and leading-zero suppression.
module seg7_scan_ctrl #(
  parameter int DIGIT_TICKS = 50000,
  parameter int BLANK_TICKS = 2000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        lz_en,
  input  logic        load_valid,
  input  logic [15:0] load_data,
  output logic        load_ready,
  output logic [3:0]  bcd,
  output logic [3:0]  an_n,
  output logic        frame_done
);

  localparam int TW = (DIGIT_TICKS > 2) ? $clog2(DIGIT_TICKS) : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(DIGIT_TICKS - 1);
  localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_TICKS - 1);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [1:0]    dig_q, dig_d;
  logic [15:0]   active_q, active_d;
  logic [15:0]   pend_q, pend_d;
  logic          pend_v_q, pend_v_d;
  logic [3:0]    bcd_q, bcd_d;
  logic [3:0]    an_q, an_d;

  logic          load_accept;
  logic          commit;
  logic [15:0]   upper;
  logic          suppress;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      tick_q   <= '0;
      dig_q    <= '0;
      active_q <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      bcd_q    <= 4'h0;
      an_q     <= 4'hF;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      dig_q    <= dig_d;
      active_q <= active_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      bcd_q    <= bcd_d;
      an_q     <= an_d;
    end
  end

  // Scan sequencing; dropping en always wins and rewinds the scan to digit 0.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    dig_d   = dig_q;
    if (!en) begin
      state_d = IDLE;
      tick_d  = '0;
      dig_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = BLANK;
          tick_d  = '0;
          dig_d   = '0;
        end
        BLANK: begin
          tick_d = tick_q + 1'b1;
          if (tick_q == BLANK_LAST) state_d = SHOW;
        end
        SHOW: begin
          if (tick_q == TICK_LAST) begin
            state_d = BLANK;
            tick_d  = '0;
            dig_d   = dig_q + 2'd1;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          tick_d  = '0;
          dig_d   = '0;
        end
      endcase
    end
  end

  assign frame_done  = (state_q == SHOW) && (dig_q == 2'd3) && (tick_q == TICK_LAST);
  assign load_ready  = ~pend_v_q;
  assign load_accept = load_valid & ~pend_v_q;
  // A pending value only ever commits on a frame boundary, or straight away while idle.
  assign commit      = pend_v_q & (frame_done | (state_q == IDLE));

  always_comb begin
    active_d = commit ? pend_q : active_q;
    pend_d   = load_accept ? load_data : pend_q;
    pend_v_d = pend_v_q;
    if (load_accept)  pend_v_d = 1'b1;
    else if (commit)  pend_v_d = 1'b0;
  end

  // Outputs are computed from next-state values so the registered bcd/an_n line up
  // with the state they describe; bcd leads the anode by the whole blank phase.
  always_comb begin
    upper    = active_d >> {dig_d, 2'b00};
    suppress = lz_en && (dig_d != 2'd0) && (upper == 16'h0000);
    bcd_d    = (state_d == IDLE) ? 4'h0 : upper[3:0];
    an_d     = 4'hF;
    if ((state_d == SHOW) && !suppress) an_d = ~(4'b0001 << dig_d);
  end

  assign bcd  = bcd_q;
  assign an_n = an_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl: position-in-frame reference model plus
// directed scenario checks and a randomized soak.
module tb_seg7_scan_ctrl;
  localparam int DT = 8;
  localparam int BT = 2;
  localparam int FRAME = 4 * DT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic        lz_en = 1'b0;
  logic        load_valid = 1'b0;
  logic [15:0] load_data = 16'h0;
  logic        load_ready;
  logic [3:0]  bcd;
  logic [3:0]  an_n;
  logic        frame_done;

  int errors = 0;
  int checks = 0;

  seg7_scan_ctrl #(.DIGIT_TICKS(DT), .BLANK_TICKS(BT)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .lz_en(lz_en),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .bcd(bcd), .an_n(an_n), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Reference model: the display is described by its position p within a running frame.
  bit          m_run = 1'b0;
  int          m_p = 0;
  logic [15:0] m_active = 16'h0;
  logic [15:0] m_pend = 16'h0;
  bit          m_pend_v = 1'b0;
  bit          m_fd_now;
  int          m_slot, m_off;
  logic [15:0] m_upper;
  logic [3:0]  exp_an = 4'hF;
  logic [3:0]  exp_bcd = 4'h0;
  logic        exp_fd = 1'b0;
  logic        exp_rdy = 1'b1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 0; m_p = 0; m_active = 16'h0; m_pend = 16'h0; m_pend_v = 0;
    end else begin
      m_fd_now = m_run && (m_p == FRAME - 1);
      if (m_pend_v && (m_fd_now || !m_run)) begin
        m_active = m_pend;
        m_pend_v = 0;
      end else if (load_valid && !m_pend_v) begin
        m_pend = load_data;
        m_pend_v = 1;
      end
      if (!en) begin
        m_run = 0; m_p = 0;
      end else if (!m_run) begin
        m_run = 1; m_p = 0;
      end else begin
        m_p = (m_p + 1) % FRAME;
      end
    end
    m_slot  = m_p / DT;
    m_off   = m_p % DT;
    m_upper = m_active >> (4 * m_slot);
    exp_bcd = m_run ? m_upper[3:0] : 4'h0;
    exp_an  = (m_run && m_off >= BT && !(lz_en && m_slot != 0 && m_upper == 16'h0))
              ? ~(4'b0001 << m_slot) : 4'hF;
    exp_fd  = m_run && (m_p == FRAME - 1);
    exp_rdy = !m_pend_v;
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    if ({an_n, bcd, load_ready, frame_done} !== {4'hF, 4'h0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_hold got an=%b bcd=%h rdy=%b fd=%b want an=1111 bcd=0 rdy=1 fd=0",
               an_n, bcd, load_ready, frame_done);
    end
    checks++;
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if ({an_n, bcd, frame_done, load_ready} !== {exp_an, exp_bcd, exp_fd, exp_rdy} || an_n !== 4'hF) begin
        errors++;
        $display("FAIL reset_idle got an=%b bcd=%h fd=%b rdy=%b want an=%b bcd=%h fd=%b rdy=%b",
                 an_n, bcd, frame_done, load_ready, exp_an, exp_bcd, exp_fd, exp_rdy);
      end
      checks++;
    end
    $display("reset: done");
  endtask

  task automatic test_load_idle();
    logic [3:0] want_an, want_bcd;
    en = 1'b0;
    load_valid = 1'b1; load_data = 16'h1234;
    cyc();
    load_valid = 1'b0;
    if (load_ready !== 1'b0) begin
      errors++; $display("FAIL idle_ready_low got rdy=%b want 0", load_ready);
    end
    checks++;
    cyc();
    if (load_ready !== 1'b1) begin
      errors++; $display("FAIL idle_ready_back got rdy=%b want 1", load_ready);
    end
    checks++;
    $display("load 1234 in idle");
    en = 1'b1;
    for (int i = 1; i <= FRAME; i++) begin
      cyc();
      want_an  = (((i - 1) % DT) >= BT) ? ~(4'b0001 << ((i - 1) / DT)) : 4'hF;
      want_bcd = 4'(4 - (i - 1) / DT);
      if (an_n !== want_an || bcd !== want_bcd || frame_done !== (i == FRAME) ||
          {an_n, bcd, frame_done, load_ready} !== {exp_an, exp_bcd, exp_fd, exp_rdy}) begin
        errors++;
        $display("FAIL idle_frame cyc=%0d got an=%b bcd=%h fd=%b want an=%b bcd=%h fd=%b",
                 i, an_n, bcd, frame_done, want_an, want_bcd, (i == FRAME));
      end
      checks++;
    end
  endtask

  task automatic test_deferred();
    bit seen_fd = 0;
    bit checked_ready = 0;
    logic [15:0] shown;
    int k;
    for (int i = 0; i < 10; i++) cyc();
    if (load_ready !== 1'b1) begin
      errors++; $display("FAIL defer_ready_pre got rdy=%b want 1", load_ready);
    end
    checks++;
    load_valid = 1'b1; load_data = 16'h5678;
    cyc();
    load_valid = 1'b0;
    $display("load 5678 mid-frame");
    for (int i = 0; i < 2 * FRAME; i++) begin
      shown = seen_fd ? 16'h5678 : 16'h1234;
      k = (an_n == 4'b1110) ? 0 : (an_n == 4'b1101) ? 1 : (an_n == 4'b1011) ? 2 : 3;
      if ((!seen_fd && load_ready !== 1'b0) ||
          (an_n !== 4'hF && bcd !== 4'((shown >> (4 * k)) & 16'hF)) ||
          {an_n, bcd, frame_done, load_ready} !== {exp_an, exp_bcd, exp_fd, exp_rdy}) begin
        errors++;
        $display("FAIL defer_frame i=%0d got an=%b bcd=%h fd=%b rdy=%b want an=%b bcd=%h fd=%b rdy=%b",
                 i, an_n, bcd, frame_done, load_ready, exp_an, exp_bcd, exp_fd, exp_rdy);
      end
      checks++;
      if (seen_fd && !checked_ready) begin
        checked_ready = 1;
        if (load_ready !== 1'b1) begin
          errors++; $display("FAIL defer_ready_after_fd got rdy=%b want 1", load_ready);
        end
        checks++;
      end
      if (frame_done === 1'b1) seen_fd = 1;
      cyc();
    end
    if (!seen_fd) begin
      errors++; $display("FAIL defer_no_frame_done got none want one");
    end
    checks++;
  endtask

  task automatic test_lz();
    logic [15:0] vals [2];
    int cnt [4];
    int n;
    vals[0] = 16'h0050; vals[1] = 16'h0000;
    lz_en = 1'b1;
    for (int v = 0; v < 2; v++) begin
      n = 0;
      while (load_ready !== 1'b1 && n < 100) begin cyc(); n++; end
      load_valid = 1'b1; load_data = vals[v];
      cyc();
      load_valid = 1'b0;
      $display("load %h with lz_en=1", vals[v]);
      n = 0;
      while (frame_done !== 1'b1 && n < 100) begin cyc(); n++; end
      if (n >= 100) begin
        errors++; $display("FAIL lz_wait_frame got timeout want frame_done");
      end
      checks++;
      for (int d = 0; d < 4; d++) cnt[d] = 0;
      for (int i = 0; i < FRAME; i++) begin
        cyc();
        if (an_n == 4'b1110) cnt[0]++;
        if (an_n == 4'b1101) cnt[1]++;
        if (an_n == 4'b1011) cnt[2]++;
        if (an_n == 4'b0111) cnt[3]++;
        if ((an_n == 4'b1101 && bcd !== 4'h5) || (an_n == 4'b1110 && bcd !== 4'h0) ||
            {an_n, bcd, frame_done, load_ready} !== {exp_an, exp_bcd, exp_fd, exp_rdy}) begin
          errors++;
          $display("FAIL lz_frame val=%h i=%0d got an=%b bcd=%h want an=%b bcd=%h",
                   vals[v], i, an_n, bcd, exp_an, exp_bcd);
        end
        checks++;
      end
      if (cnt[0] != DT - BT || cnt[1] != ((v == 0) ? DT - BT : 0) || cnt[2] != 0 || cnt[3] != 0) begin
        errors++;
        $display("FAIL lz_counts val=%h got d0=%0d d1=%0d d2=%0d d3=%0d want d0=%0d d1=%0d d2=0 d3=0",
                 vals[v], cnt[0], cnt[1], cnt[2], cnt[3], DT - BT, (v == 0) ? DT - BT : 0);
      end
      checks++;
    end
    lz_en = 1'b0;
  endtask

  task automatic test_enable_drop();
    logic [3:0] want_an [5];
    logic       want_rdy [5];
    int n = 0;
    while (an_n !== 4'b1110 && n < 100) begin cyc(); n++; end
    load_valid = 1'b1; load_data = 16'hABCD;
    cyc();
    load_valid = 1'b0;
    $display("load abcd before enable drop");
    while (an_n !== 4'b1011 && n < 200) begin cyc(); n++; end
    if (n >= 200) begin
      errors++; $display("FAIL drop_wait_digit2 got timeout want an=1011");
    end
    checks++;
    want_an[0] = 4'hF; want_an[1] = 4'hF; want_an[2] = 4'hF; want_an[3] = 4'hF; want_an[4] = 4'b1110;
    want_rdy[0] = 1'b0; want_rdy[1] = 1'b1; want_rdy[2] = 1'b1; want_rdy[3] = 1'b1; want_rdy[4] = 1'b1;
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (i == 1) en = 1'b1;
      if (an_n !== want_an[i] || load_ready !== want_rdy[i] || (i >= 2 && bcd !== 4'hD) ||
          {an_n, bcd, frame_done, load_ready} !== {exp_an, exp_bcd, exp_fd, exp_rdy}) begin
        errors++;
        $display("FAIL drop_step%0d got an=%b bcd=%h rdy=%b want an=%b bcd=%h rdy=%b",
                 i, an_n, bcd, load_ready, want_an[i], (i >= 2) ? 4'hD : exp_bcd, want_rdy[i]);
      end
      checks++;
    end
  endtask

  task automatic test_nibbles();
    en = 1'b0;
    lz_en = 1'b0;
    cyc();
    cyc();
    for (int v = 0; v < 16; v++) begin
      load_valid = 1'b1;
      load_data = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'(v)};
      cyc();
      load_valid = 1'b0;
      cyc();
      en = 1'b1;
      for (int i = 0; i < BT + 1; i++) cyc();
      if (an_n !== 4'b1110 || bcd !== 4'(v) ||
          {an_n, bcd, frame_done, load_ready} !== {exp_an, exp_bcd, exp_fd, exp_rdy}) begin
        errors++;
        $display("FAIL nibble_%0d got an=%b bcd=%h want an=1110 bcd=%h", v, an_n, bcd, 4'(v));
      end
      checks++;
      en = 1'b0;
      cyc();
    end
  endtask

  task automatic test_random();
    int loads = 0;
    for (int i = 0; i < 1500; i++) begin
      en = ($urandom_range(0, 60) != 0);
      if ($urandom_range(0, 200) == 0) lz_en = ~lz_en;
      load_valid = ($urandom_range(0, 7) == 0);
      load_data = 16'($urandom());
      if (load_valid && load_ready) loads++;
      cyc();
      if ({an_n, bcd, frame_done, load_ready} !== {exp_an, exp_bcd, exp_fd, exp_rdy}) begin
        errors++;
        $display("FAIL random i=%0d got an=%b bcd=%h fd=%b rdy=%b want an=%b bcd=%h fd=%b rdy=%b",
                 i, an_n, bcd, frame_done, load_ready, exp_an, exp_bcd, exp_fd, exp_rdy);
      end
      checks++;
    end
    load_valid = 1'b0;
    $display("random: %0d loads offered while ready", loads);
  endtask

  task automatic test_reset_mid();
    int n = 0;
    en = 1'b1;
    lz_en = 1'b0;
    while (load_ready !== 1'b1 && n < 200) begin cyc(); n++; end
    load_valid = 1'b1; load_data = 16'h9999;
    cyc();
    load_valid = 1'b0;
    while (an_n === 4'hF && n < 200) begin cyc(); n++; end
    if (n >= 200) begin
      errors++; $display("FAIL rstmid_wait_show got timeout want show phase");
    end
    checks++;
    rst_n = 1'b0;
    #1;
    if ({an_n, bcd, load_ready, frame_done} !== {4'hF, 4'h0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL rstmid_async got an=%b bcd=%h rdy=%b fd=%b want an=1111 bcd=0 rdy=1 fd=0",
               an_n, bcd, load_ready, frame_done);
    end
    checks++;
    #2 rst_n = 1'b1;
    for (int i = 0; i < DT; i++) begin
      cyc();
      if (bcd !== 4'h0 || {an_n, bcd, frame_done, load_ready} !== {exp_an, exp_bcd, exp_fd, exp_rdy}) begin
        errors++;
        $display("FAIL rstmid_after i=%0d got an=%b bcd=%h rdy=%b want an=%b bcd=0 rdy=%b",
                 i, an_n, bcd, load_ready, exp_an, exp_rdy);
      end
      checks++;
    end
  endtask

  initial begin
    test_reset();
    test_load_idle();
    test_deferred();
    test_lz();
    test_enable_drop();
    test_nibbles();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
